xilinx_bram_sdp: RTL
====================

// Module: xilinx_bram_sdp
// PURPOSE
//   Parametrised simple-dual-port block RAM: one write port, one read port, one clock.
//   Successor to xilinx_bram, replacing its shared address with separate read and write addresses.
//   Adds byte-enable writes, a selectable read latency and a defined read-during-write result.
//   Adds an optional zero-fill sweep after reset.
//   Used as the generic packet/metadata store in fpgashark; infers RAMB18/RAMB36 primitives.
// PARAMETERS
//   ADDR_WIDTH      10  address bits; DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH      16  word width; must be a multiple of 8 (elaboration $error otherwise)
//   READ_LATENCY    1   1 = BRAM output only; 2 = extra output register (DOB_REG); other values $error
//   RDW_MODE        0   same-address read+write in one cycle: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data)
//   CLEAR_ON_RESET  1   1 = zero every word after reset; 0 = contents untouched by reset
// PORTS
//   clk         in   1                clock; all logic on rising edge
//   rst_n       in   1                reset, synchronous, active-low
//   write_en    in   1                write strobe
//   write_addr  in   ADDR_WIDTH       write address
//   write_data  in   DATA_WIDTH       write data
//   write_be    in   DATA_WIDTH/8     byte enables; bit k gates write_data[8k+7:8k]
//   read_en     in   1                read strobe
//   read_addr   in   ADDR_WIDTH       read address
//   read_data   out  DATA_WIDTH       read result; holds its value while valid=0
//   valid       out  1                one-cycle pulse: read_data carries a requested word
//   init_done   out  1                1 = RAM accepts reads/writes
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): read_data=0, valid=0, init_done=0, latency pipe flushed, sweep counter=0.
//     State goes to CLEAR if CLEAR_ON_RESET=1, else to READY. Reads in flight are discarded and never produce valid.
//   FSM CLEAR: each cycle writes 0 to address sweep_cnt, then sweep_cnt++.
//     After writing DEPTH-1, go to READY. init_done rises on the edge that writes DEPTH-1 (DEPTH edges after release).
//     In CLEAR, external write_en/read_en are ignored: no write, no valid. There is no backpressure; callers wait for init_done.
//     rst_n low mid-sweep restarts the sweep from address 0.
//   FSM READY: init_done=1 (registered). With CLEAR_ON_RESET=0, it rises on the first edge with rst_n=1.
//   Write: at an edge with write_en=1 in READY, mem[write_addr] bytes with write_be=1 take write_data; other bytes keep their value.
//     write_be=0 with write_en=1 is a legal no-op.
//   Read: read_en=1 in READY at edge N -> valid=1 and read_data=mem[read_addr] after edge N+READ_LATENCY-1
//     (visible during cycle N+READ_LATENCY). Full throughput: one read per cycle, valid back-to-back.
//   Read-during-write, same address, same edge:
//     READ_FIRST returns the pre-write word.
//     WRITE_FIRST returns the post-write word: enabled bytes new, disabled bytes old.
//     Different addresses: no interaction.
//   A write landing between a read's issue and its valid does not alter that read's data.
//   Addresses are always in range (DEPTH = 2**ADDR_WIDTH); no wrap logic required.
// TESTING
//   T1 ADDR_WIDTH=4, CLEAR_ON_RESET=1: release rst_n.
//      -> init_done=0 for 15 cycles, 1 from the 16th edge; reads of 0..15 all return 0x0000.
//   T2 write 0xA000+i to addr i (i=0..4), then read 0..4 on consecutive cycles.
//      -> valid high 5 cycles, data A000..A004 in order, after latency 1; repeat with READ_LATENCY=2.
//   T3 write 0x1234 be=11 to 0x3A, then write 0xABCD be=01 to 0x3A, then read 0x3A -> 0x12CD.
//   T4 0x3A holds 0x1234; same edge: write 0x5678 be=11 + read 0x3A.
//      -> READ_FIRST 0x1234, WRITE_FIRST 0x5678. With be=10, WRITE_FIRST returns 0x5634.
//   T5 write_en/read_en pulsed during CLEAR sweep -> no valid, and after init_done the target word still reads 0x0000.
//   T6 rst_n low for 1 cycle with 2 reads in flight (READ_LATENCY=2) and mid-sweep.
//      -> valid stays 0, read_data=0, the sweep restarts, and init_done rises DEPTH edges after release.

Source files
------------

// File: rtl/xilinx_bram_sdp.sv
// Simple-dual-port block RAM with byte-enable writes, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and an optional zero-fill sweep after reset.
module xilinx_bram_sdp #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write_en,
    input  logic [ADDR_WIDTH-1:0]     write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH/8-1:0]   write_be,
    input  logic                      read_en,
    input  logic [ADDR_WIDTH-1:0]     read_addr,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      valid,
    output logic                      init_done
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("xilinx_bram_sdp: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("xilinx_bram_sdp: READ_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
        $error("xilinx_bram_sdp: RDW_MODE must be 0 or 1");
    end

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  ready;

    assign ready = (state == ST_READY);

    // Sweep and init_done sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            sweep_cnt <= '0;
            init_done <= 1'b0;
        end else if (state == ST_CLEAR) begin
            sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
            if (sweep_cnt == '1) begin
                state     <= ST_READY;
                init_done <= 1'b1;
            end
        end else begin
            init_done <= 1'b1;
        end
    end

    // The sweep shares the single write port; external traffic is ignored until ready.
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NBYTES-1:0]     mem_wbe;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        mem_wbe   = write_be;
        if (rst_n) begin
            if (ready) begin
                mem_we = write_en;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = sweep_cnt;
                mem_wdata = '0;
                mem_wbe   = '1;
            end
        end
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (mem_wbe[k]) begin
                    mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_word;

    assign rd_fire = rst_n && ready && read_en;
    assign rd_old  = mem[read_addr];

    // WRITE_FIRST forwards the enabled bytes of a same-edge write to the same address.
    always_comb begin
        rd_word = rd_old;
        if (RDW_MODE == 1 && mem_we && mem_waddr == read_addr) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (mem_wbe[k]) begin
                    rd_word[8*k +: 8] = mem_wdata[8*k +: 8];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_data;
        logic                  s1_valid;

        always_ff @(posedge clk) begin
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_valid  <= 1'b0;
                valid     <= 1'b0;
                read_data <= '0;
            end else begin
                s1_valid <= rd_fire;
                valid    <= s1_valid;
                if (s1_valid) begin
                    read_data <= s1_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid     <= 1'b0;
                read_data <= '0;
            end else begin
                valid <= rd_fire;
                if (rd_fire) begin
                    read_data <= rd_word;
                end
            end
        end
    end

endmodule
